// File: rtl/map_dot_eater_if.sv
// Bundle between the dot-eater, its requester and map RAM port B.
// slave: the dot-eater. master: the requester and the RAM side.
interface map_dot_eater_if #(
  parameter int COLS    = 160,
  parameter int SCORE_W = 16
);
  logic               req;
  logic [4:0]         row;
  logic [7:0]         col;
  logic               new_level;
  logic               busy;
  logic               done;
  logic               eaten;
  logic [SCORE_W-1:0] score;
  logic [7:0]         dots_left;
  logic               level_clear;
  logic [4:0]         ram_addr;
  logic [COLS-1:0]    ram_wrdata;
  logic               ram_wren;
  logic [COLS-1:0]    ram_q;

  modport master (
    output req, row, col, new_level, ram_q,
    input  busy, done, eaten, score, dots_left,
    input  level_clear, ram_addr, ram_wrdata, ram_wren
  );

  modport slave (
    input  req, row, col, new_level, ram_q,
    output busy, done, eaten, score, dots_left,
    output level_clear, ram_addr, ram_wrdata, ram_wren
  );
endinterface

// File: rtl/map_dot_eater.sv
// Read-modify-write dot clearer on map RAM port B; keeps score/dots.
// Ports: clock, reset_n (sync, active-low), io (slave bundle).
module map_dot_eater #(
  parameter int ROWS       = 32,
  parameter int COLS       = 160,
  parameter int RD_LATENCY = 2,
  parameter int TOTAL_DOTS = 240,
  parameter int POINTS     = 10,
  parameter int SCORE_W    = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  map_dot_eater_if.slave io
);

  localparam int CW = $clog2(RD_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MODIFY,
    S_WRITE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         row_q, row_d;
  logic [7:0]         col_q, col_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               hit_q, hit_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               eaten_q, eaten_d;
  logic               wren_q, wren_d;
  logic [4:0]         addr_q, addr_d;
  logic [COLS-1:0]    wdat_q, wdat_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [7:0]         dots_q, dots_d;

  logic [COLS-1:0]    mask;
  logic [SCORE_W:0]   sum;
  logic               in_rng;

  assign mask   = COLS'(1) << col_q;
  assign sum    = {1'b0, score_q} + (SCORE_W+1)'(POINTS);
  assign in_rng = (32'(col_q) < COLS) && (32'(row_q) < ROWS);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eaten_q <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      score_q <= '0;
      dots_q  <= 8'(TOTAL_DOTS);
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eaten_q <= eaten_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      score_q <= score_d;
      dots_q  <= dots_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    eaten_d = 1'b0;
    wren_d  = 1'b0;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    score_d = score_q;
    dots_d  = dots_q;
    unique case (state_q)
      S_IDLE: begin
        if (io.new_level) begin
          dots_d = 8'(TOTAL_DOTS);
        end else if (io.req) begin
          row_d   = io.row;
          col_d   = io.col;
          addr_d  = io.row;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (cnt_q == CW'(RD_LATENCY)) begin
          state_d = S_MODIFY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MODIFY: begin
        if (in_rng && io.ram_q[col_q]) begin
          wdat_d = io.ram_q & ~mask;
          wren_d = 1'b1;
          hit_d  = 1'b1;
        end else begin
          hit_d  = 1'b0;
        end
        state_d = S_WRITE;
      end
      S_WRITE: begin
        done_d  = 1'b1;
        eaten_d = hit_q;
        busy_d  = 1'b0;
        if (hit_q) begin
          score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
          if (dots_q != '0) dots_d = dots_q - 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign io.busy        = busy_q;
  assign io.done        = done_q;
  assign io.eaten       = eaten_q;
  assign io.score       = score_q;
  assign io.dots_left   = dots_q;
  assign io.level_clear = (dots_q == '0);
  assign io.ram_addr    = addr_q;
  assign io.ram_wrdata  = wdat_q;
  assign io.ram_wren    = wren_q;

endmodule
